// File: rtl/game_collision_pkg.sv
// Shared types and helpers for the multi-object collision controller.
package game_collision_pkg;

  localparam int unsigned DEFAULT_NUM_OBJ = 8;

  typedef enum logic {
    READY,
    LOCKED
  } lock_state_e;

  // Index width for n codes, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder with a valid flag.
module prio_enc_lsb #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !valid) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_object_collision_ctrl.sv
// Hook/object/border collision arbiter: per-frame capture, queued one-cycle
// hit pulses, frame summaries, saturating hit counter and post-hit lockout.
module multi_object_collision_ctrl
  import game_collision_pkg::*;
#(
  parameter int unsigned NUM_OBJ           = DEFAULT_NUM_OBJ,
  parameter int unsigned IDX_W             = idx_width(NUM_OBJ),
  parameter bit          ONE_HIT_PER_FRAME = 1'b0,
  parameter int unsigned LOCKOUT_FRAMES    = 2,
  parameter int unsigned CNT_W             = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               drawing_request_hook,
  input  logic               drawing_request_boarders,
  input  logic [NUM_OBJ-1:0] drawing_request_obj,
  output logic               collision,
  output logic               borderHitPulse,
  output logic               hitPulse,
  output logic [IDX_W-1:0]   hitIndex,
  output logic [NUM_OBJ-1:0] frameHitVector,
  output logic [CNT_W-1:0]   hitCount,
  output logic               locked
);

  localparam int unsigned LCK_W = idx_width(LOCKOUT_FRAMES + 1);

  logic [NUM_OBJ-1:0] obj_flag_q, obj_flag_d;
  logic [NUM_OBJ-1:0] pending_q, pending_d;
  logic [NUM_OBJ-1:0] acc_q, acc_d;
  logic [NUM_OBJ-1:0] frame_vec_q, frame_vec_d;
  logic               frame_flag_q, frame_flag_d;
  logic               border_flag_q, border_flag_d;
  logic               border_pulse_q, border_pulse_d;
  logic               hit_pulse_q, hit_pulse_d;
  logic [IDX_W-1:0]   hit_index_q, hit_index_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  lock_state_e        lock_state_q, lock_state_d;
  logic [LCK_W-1:0]   lock_cnt_q, lock_cnt_d;

  logic [NUM_OBJ-1:0] cand;
  logic [NUM_OBJ-1:0] cap;
  logic [NUM_OBJ-1:0] drain_req;
  logic [NUM_OBJ-1:0] drain_clr;
  logic [IDX_W-1:0]   drain_idx;
  logic               drain_valid;
  logic               lock_active;
  logic               border_hit;

  assign lock_active = (lock_state_q == LOCKED);
  assign border_hit  = drawing_request_hook && drawing_request_boarders && !border_flag_q;

  assign cand = drawing_request_obj & ~obj_flag_q &
                {NUM_OBJ{drawing_request_hook && !lock_active &&
                         !(ONE_HIT_PER_FRAME && frame_flag_q)}};

  generate
    if (ONE_HIT_PER_FRAME) begin : g_single_capture
      logic [IDX_W-1:0] cap_idx;
      logic             cap_valid;

      prio_enc_lsb #(
        .N  (NUM_OBJ),
        .IW (IDX_W)
      ) u_cap_enc (
        .req   (cand),
        .idx   (cap_idx),
        .valid (cap_valid)
      );

      assign cap = cap_valid ? (NUM_OBJ'(1) << cap_idx) : '0;
    end else begin : g_all_capture
      assign cap = cand;
    end
  endgenerate

  // Fresh captures join the drain directly, giving a one-cycle capture-to-pulse path.
  assign drain_req = pending_q | cap;

  prio_enc_lsb #(
    .N  (NUM_OBJ),
    .IW (IDX_W)
  ) u_drain_enc (
    .req   (drain_req),
    .idx   (drain_idx),
    .valid (drain_valid)
  );

  always_comb begin
    drain_clr   = '0;
    pending_d   = drain_req;
    hit_pulse_d = drain_valid;
    hit_index_d = hit_index_q;
    hit_cnt_d   = hit_cnt_q;
    if (drain_valid) begin
      drain_clr   = NUM_OBJ'(1) << drain_idx;
      pending_d   = drain_req & ~drain_clr;
      hit_index_d = drain_idx;
      if (hit_cnt_q != '1) begin
        hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end
    end
  end

  // A capture coincident with startOfFrame belongs to the new frame's flags
  // but is reported in the closing frame's summary, not the new accumulator.
  always_comb begin
    border_pulse_d = border_hit;
    if (startOfFrame) begin
      obj_flag_d    = cap;
      frame_flag_d  = |cap;
      frame_vec_d   = acc_q | cap;
      acc_d         = '0;
      border_flag_d = border_hit;
    end else begin
      obj_flag_d    = obj_flag_q | cap;
      frame_flag_d  = frame_flag_q | (|cap);
      frame_vec_d   = frame_vec_q;
      acc_d         = acc_q | cap;
      border_flag_d = border_flag_q | border_hit;
    end
  end

  always_comb begin
    lock_state_d = lock_state_q;
    lock_cnt_d   = lock_cnt_q;
    case (lock_state_q)
      READY: begin
        if (hit_pulse_q && (LOCKOUT_FRAMES != 0)) begin
          lock_state_d = LOCKED;
          lock_cnt_d   = LCK_W'(LOCKOUT_FRAMES);
        end
      end
      LOCKED: begin
        if (hit_pulse_q) begin
          lock_cnt_d = LCK_W'(LOCKOUT_FRAMES);
        end else if (startOfFrame) begin
          if (lock_cnt_q <= LCK_W'(1)) begin
            lock_state_d = READY;
            lock_cnt_d   = '0;
          end else begin
            lock_cnt_d = lock_cnt_q - LCK_W'(1);
          end
        end
      end
      default: begin
        lock_state_d = READY;
        lock_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      obj_flag_q     <= '0;
      pending_q      <= '0;
      acc_q          <= '0;
      frame_vec_q    <= '0;
      frame_flag_q   <= 1'b0;
      border_flag_q  <= 1'b0;
      border_pulse_q <= 1'b0;
      hit_pulse_q    <= 1'b0;
      hit_index_q    <= '0;
      hit_cnt_q      <= '0;
      lock_state_q   <= READY;
      lock_cnt_q     <= '0;
    end else begin
      obj_flag_q     <= obj_flag_d;
      pending_q      <= pending_d;
      acc_q          <= acc_d;
      frame_vec_q    <= frame_vec_d;
      frame_flag_q   <= frame_flag_d;
      border_flag_q  <= border_flag_d;
      border_pulse_q <= border_pulse_d;
      hit_pulse_q    <= hit_pulse_d;
      hit_index_q    <= hit_index_d;
      hit_cnt_q      <= hit_cnt_d;
      lock_state_q   <= lock_state_d;
      lock_cnt_q     <= lock_cnt_d;
    end
  end

  assign collision      = drawing_request_hook &&
                          (drawing_request_boarders || (|drawing_request_obj));
  assign borderHitPulse = border_pulse_q;
  assign hitPulse       = hit_pulse_q;
  assign hitIndex       = hit_index_q;
  assign frameHitVector = frame_vec_q;
  assign hitCount       = hit_cnt_q;
  assign locked         = lock_lock_out();

  function automatic logic lock_lock_out();
    return lock_active;
  endfunction

endmodule
